// File: rtl/pwm_pkg.sv
// Shared types and defaults for the PWM period/high-time meter.
package pwm_pkg;

    localparam int CNT_W_DEF = 8;

    typedef enum logic [1:0] {
        S_SYNC = 2'd0,
        S_HIGH = 2'd1,
        S_LOW  = 2'd2
    } state_t;

endpackage

// File: rtl/pwm_meas_if.sv
// Bundle of the PWM input and its measurement results, for hookup by a driver or monitor.
interface pwm_meas_if #(
    parameter int CNT_W = 8
);
    logic             pwm;
    logic [CNT_W-1:0] high;
    logic [CNT_W-1:0] period;
    logic             valid;
    logic             stuck;
    logic             level;

    modport master (input pwm, output high, output period, output valid, output stuck, output level);
    modport slave  (output pwm, input high, input period, input valid, input stuck, input level);
endinterface

// File: rtl/pwm_edge_det.sv
// Samples i_pwm (two-flop synchronizer when PWM_MEAS_SYNC_EN is defined) and flags rising/falling edges.
// prev resets high so a level already high at reset release never reads as a rising edge.
module pwm_edge_det (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_pwm,
    output logic o_s,
    output logic o_rise,
    output logic o_fall
);
    logic s;
    logic s_ok;
    logic prev_q, prev_d;

`ifdef PWM_MEAS_SYNC_EN
    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic fill1_q, fill1_d;
    logic fill2_q, fill2_d;

    // fill flags mark when the synchronizer holds real samples instead of reset zeros
    always_comb begin
        sync1_d = i_pwm;
        sync2_d = sync1_q;
        fill1_d = 1'b1;
        fill2_d = fill1_q;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            fill1_q <= 1'b0;
            fill2_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            fill1_q <= fill1_d;
            fill2_q <= fill2_d;
        end
    end

    assign s    = sync2_q;
    assign s_ok = fill2_q;
`else
    assign s    = i_pwm;
    assign s_ok = 1'b1;
`endif

    always_comb begin
        prev_d = s_ok ? s : 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) prev_q <= 1'b1;
        else       prev_q <= prev_d;
    end

    assign o_s    = s;
    assign o_rise = s & ~prev_q;
    assign o_fall = ~s & prev_q;

endmodule

// File: rtl/pwm_meas.sv
// Measures high time and period of i_pwm in clock cycles; flags a stuck input on counter timeout.
// Build option PWM_MEAS_SYNC_EN adds a two-flop input synchronizer (2 extra cycles of latency).
module pwm_meas
    import pwm_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_pwm,
    output logic [CNT_W-1:0] o_high,
    output logic [CNT_W-1:0] o_period,
    output logic             o_valid,
    output logic             o_stuck,
    output logic             o_level
);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [CNT_W-1:0] period_cnt_q, period_cnt_d;
    logic [CNT_W-1:0] high_cnt_q, high_cnt_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] period_inc, high_inc;
    logic             valid_q, valid_d;
    logic             stuck_q, stuck_d;
    logic             level_q, level_d;
    logic             s, rise, fall;

    pwm_edge_det u_edge (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_pwm  (i_pwm),
        .o_s    (s),
        .o_rise (rise),
        .o_fall (fall)
    );

    always_comb begin
        period_inc   = (period_cnt_q == CNT_MAX) ? CNT_MAX : period_cnt_q + CNT_ONE;
        high_inc     = (high_cnt_q == CNT_MAX) ? CNT_MAX : high_cnt_q + CNT_ONE;
        state_d      = state_q;
        period_cnt_d = period_cnt_q;
        high_cnt_d   = high_cnt_q;
        high_d       = high_q;
        period_d     = period_q;
        valid_d      = 1'b0;
        stuck_d      = stuck_q;
        level_d      = level_q;

        case (state_q)
            S_SYNC: begin
                if (rise) begin
                    state_d      = S_HIGH;
                    period_cnt_d = CNT_ONE;
                    high_cnt_d   = CNT_ONE;
                    stuck_d      = 1'b0;
                end
            end
            S_HIGH: begin
                period_cnt_d = period_inc;
                // a full-scale period means the input stopped toggling
                if (period_inc == CNT_MAX) begin
                    state_d = S_SYNC;
                    stuck_d = 1'b1;
                    level_d = s;
                end else if (fall) begin
                    state_d = S_LOW;
                end else begin
                    high_cnt_d = high_inc;
                end
            end
            S_LOW: begin
                if (rise) begin
                    high_d       = high_cnt_q;
                    period_d     = period_cnt_q;
                    valid_d      = 1'b1;
                    period_cnt_d = CNT_ONE;
                    high_cnt_d   = CNT_ONE;
                    state_d      = S_HIGH;
                end else begin
                    period_cnt_d = period_inc;
                    if (period_inc == CNT_MAX) begin
                        state_d = S_SYNC;
                        stuck_d = 1'b1;
                        level_d = s;
                    end
                end
            end
            default: state_d = S_SYNC;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= S_SYNC;
            period_cnt_q <= '0;
            high_cnt_q   <= '0;
            high_q       <= '0;
            period_q     <= '0;
            valid_q      <= 1'b0;
            stuck_q      <= 1'b0;
            level_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            period_cnt_q <= period_cnt_d;
            high_cnt_q   <= high_cnt_d;
            high_q       <= high_d;
            period_q     <= period_d;
            valid_q      <= valid_d;
            stuck_q      <= stuck_d;
            level_q      <= level_d;
        end
    end

    assign o_high   = high_q;
    assign o_period = period_q;
    assign o_valid  = valid_q;
    assign o_stuck  = stuck_q;
    assign o_level  = level_q;

endmodule

// File: tb/tb_pwm_meas.sv
// Directed bench for pwm_meas: waveform table plus reset, timeout and recovery sequences.
`timescale 1ns/1ps
module tb_pwm_meas;

`ifdef PWM_MEAS_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    typedef struct {
        int h;
        int l;
        int n;
        int exp_h;
        int exp_p;
    } vec_t;

    typedef struct {
        int t;
        int h;
        int p;
    } ev_t;

    logic clk = 1'b0;
    logic rst;
    logic rst4;
    int   cyc = 0;
    int   nvec = 0;
    int   nerr = 0;
    ev_t  evq[$];
    ev_t  evq4[$];
    vec_t vt[5];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pwm_meas_if #(.CNT_W(8)) mif ();
    pwm_meas_if #(.CNT_W(4)) mif4 ();

    pwm_meas #(.CNT_W(8)) u_dut (
        .i_clk(clk), .i_rst(rst), .i_pwm(mif.pwm),
        .o_high(mif.high), .o_period(mif.period), .o_valid(mif.valid),
        .o_stuck(mif.stuck), .o_level(mif.level)
    );

    pwm_meas #(.CNT_W(4)) u_dut4 (
        .i_clk(clk), .i_rst(rst4), .i_pwm(mif4.pwm),
        .o_high(mif4.high), .o_period(mif4.period), .o_valid(mif4.valid),
        .o_stuck(mif4.stuck), .o_level(mif4.level)
    );

    // log every o_valid pulse with its cycle and payload
    always @(negedge clk) begin
        ev_t e;
        if (mif.valid) begin
            e.t = cyc; e.h = int'(mif.high); e.p = int'(mif.period);
            evq.push_back(e);
        end
        if (mif4.valid) begin
            e.t = cyc; e.h = int'(mif4.high); e.p = int'(mif4.period);
            evq4.push_back(e);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drv(input bit sel, input logic v, input int n, output int t);
        @(negedge clk);
        t = cyc;
        if (sel) mif4.pwm = v;
        else     mif.pwm  = v;
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic rst_dut(input bit sel, input logic pv);
        @(negedge clk);
        if (sel) begin rst4 = 1'b1; mif4.pwm = pv; end
        else     begin rst  = 1'b1; mif.pwm  = pv; end
        repeat (2) @(negedge clk);
        if (sel) rst4 = 1'b0;
        else     rst  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int t, t0, t1, ta, tb, tr, tq, tv, st;

        vt[0] = '{h: 6,  l: 10, n: 4, exp_h: 6,  exp_p: 16};
        vt[1] = '{h: 1,  l: 1,  n: 6, exp_h: 1,  exp_p: 2};
        vt[2] = '{h: 3,  l: 5,  n: 3, exp_h: 3,  exp_p: 8};
        vt[3] = '{h: 2,  l: 7,  n: 2, exp_h: 2,  exp_p: 9};
        vt[4] = '{h: 10, l: 1,  n: 2, exp_h: 10, exp_p: 11};

        rst = 1'b1; rst4 = 1'b1; mif.pwm = 1'b0; mif4.pwm = 1'b0;

        // reset state
        rst_dut(0, 1'b0);
        chk("rst_high",   int'(mif.high),   0);
        chk("rst_period", int'(mif.period), 0);
        chk("rst_valid",  int'(mif.valid),  0);
        chk("rst_stuck",  int'(mif.stuck),  0);
        chk("rst_level",  int'(mif.level),  0);

        // waveform table: n full periods then a closing rising edge
        for (int i = 0; i < 5; i++) begin
            rst_dut(0, 1'b0);
            evq.delete();
            drv(0, 1'b0, 3, t);
            t0 = 0;
            for (int p = 0; p < vt[i].n; p++) begin
                drv(0, 1'b1, vt[i].h, t);
                if (p == 0) t0 = t;
                drv(0, 1'b0, vt[i].l, t);
            end
            drv(0, 1'b1, 1, t);
            drv(0, 1'b0, LAT + 3, t);
            chk($sformatf("v%0d_count", i), evq.size(), vt[i].n);
            for (int k = 0; k < evq.size() && k < vt[i].n; k++) begin
                chk($sformatf("v%0d_t%0d", i, k), evq[k].t - t0, (k + 1) * (vt[i].h + vt[i].l) + LAT);
                chk($sformatf("v%0d_h%0d", i, k), evq[k].h, vt[i].exp_h);
                chk($sformatf("v%0d_p%0d", i, k), evq[k].p, vt[i].exp_p);
            end
        end

        // input high through reset release: only a genuine 0->1 edge starts a period
        @(negedge clk);
        rst = 1'b1; mif.pwm = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        evq.delete();
        drv(0, 1'b1, 3, t);
        drv(0, 1'b0, 5, t);
        drv(0, 1'b1, 3, t1);
        drv(0, 1'b0, 5, t);
        drv(0, 1'b1, 3, t);
        drv(0, 1'b0, 5, t);
        drv(0, 1'b1, 1, t);
        drv(0, 1'b0, LAT + 3, t);
        chk("hirst_count", evq.size(), 2);
        if (evq.size() > 0) begin
            chk("hirst_t", evq[0].t - t1, 8 + LAT);
            chk("hirst_h", evq[0].h, 3);
            chk("hirst_p", evq[0].p, 8);
        end

        // one-cycle reset in the middle of a high phase
        rst_dut(0, 1'b0);
        drv(0, 1'b0, 3, t);
        drv(0, 1'b1, 6, t);
        drv(0, 1'b0, 10, t);
        drv(0, 1'b1, 5, t);
        chk("mid_pre_h", int'(mif.high),   6);
        chk("mid_pre_p", int'(mif.period), 16);
        @(negedge clk);
        rst = 1'b1;
        evq.delete();
        @(negedge clk);
        rst = 1'b0;
        chk("mid_high",   int'(mif.high),   0);
        chk("mid_period", int'(mif.period), 0);
        chk("mid_valid",  int'(mif.valid),  0);
        chk("mid_stuck",  int'(mif.stuck),  0);
        chk("mid_level",  int'(mif.level),  0);
        drv(0, 1'b1, 1, t);
        drv(0, 1'b0, 10, t);
        drv(0, 1'b1, 6, ta);
        drv(0, 1'b0, 10, t);
        drv(0, 1'b1, 1, tb);
        drv(0, 1'b0, LAT + 3, t);
        chk("mid_count", evq.size(), 1);
        if (evq.size() > 0) begin
            chk("mid_t", evq[0].t - tb, LAT);
            chk("mid_h", evq[0].h, 6);
            chk("mid_p", evq[0].p, 16);
        end

        // CNT_W=4: measure 2/3, then hold high until timeout
        rst_dut(1, 1'b0);
        evq4.delete();
        drv(1, 1'b0, 3, t);
        drv(1, 1'b1, 2, t);
        drv(1, 1'b0, 3, t);
        drv(1, 1'b1, 1, tr);
        st = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (mif4.stuck) begin st = cyc; break; end
        end
        chk("stk1_t", st - tr, LAT + 14);
        chk("stk1_level", int'(mif4.level), 1);
        chk("stk1_high", int'(mif4.high), 2);
        chk("stk1_period", int'(mif4.period), 5);
        chk("stk1_count", evq4.size(), 1);
        if (evq4.size() > 0) begin
            chk("stk1_vt", evq4[0].t - tr, LAT);
            chk("stk1_vh", evq4[0].h, 2);
            chk("stk1_vp", evq4[0].p, 5);
        end

        // recovery: first edge clears stuck without a result, second edge measures
        drv(1, 1'b0, 4, t);
        chk("stk_hold", int'(mif4.stuck), 1);
        drv(1, 1'b1, 2, tq);
        drv(1, 1'b0, 3, t);
        chk("stk_clear", int'(mif4.stuck), 0);
        chk("stk_clear_count", evq4.size(), 1);

        // then 0% duty after one more measurement
        drv(1, 1'b1, 2, tv);
        drv(1, 1'b0, 1, t);
        st = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (mif4.stuck) begin st = cyc; break; end
        end
        chk("stk0_t", st - tv, LAT + 14);
        chk("stk0_level", int'(mif4.level), 0);
        chk("stk0_high", int'(mif4.high), 2);
        chk("stk0_period", int'(mif4.period), 5);
        chk("stk0_count", evq4.size(), 2);
        if (evq4.size() > 1) begin
            chk("rec_vt", evq4[1].t - tv, LAT);
            chk("rec_vh", evq4[1].h, 2);
            chk("rec_vp", evq4[1].p, 5);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
